// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and register-index type for the issue-side register scoreboard.
package reg_scoreboard_pkg;
  localparam int NUM_REGS    = 32;
  localparam int ADDR_W      = $clog2(NUM_REGS);
  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register in-flight write counter: increments on issue, decrements on
// writeback, and clears on flush.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow_pulse
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // A simultaneous inc and dec cancel out, so the count holds and no underflow is raised.
  always_comb begin
    count_d         = count_q;
    underflow_pulse = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
      else               underflow_pulse = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);
  assign full    = (count_q == CNT_MAX);
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: stalls RAW hazards and saturated destinations at issue,
// and drives the register-file write port from writeback.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IssueValid,
  input  reg_idx_t               IssueRs1,
  input  reg_idx_t               IssueRs2,
  input  reg_idx_t               IssueRd,
  input  logic                   IssueWrites,
  output logic                   IssueReady,
  input  logic                   WbValid,
  input  reg_idx_t               WbRd,
  input  logic                   Flush,
  output logic                   RegWrite,
  output reg_idx_t               WriteRegister,
  output logic [NUM_REGS-1:0]    BusyMask,
  output logic [STALL_CNT_W-1:0] StallCount,
  output logic                   Underflow
);
  logic [CNT_W-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0]    nonzero_v, full_v, uf_v;
  logic                   raw, waw_full, issue_fire;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   underflow_q, underflow_d;

  // x0 is hardwired zero and never tracked.
  assign cnt[0]       = '0;
  assign nonzero_v[0] = 1'b0;
  assign full_v[0]    = 1'b0;
  assign uf_v[0]      = 1'b0;

  // The hazard check looks only at registered counts: a same-cycle writeback
  // does not release a dependent instruction until the following cycle.
  assign raw        = (IssueRs1 != REG_ZERO && cnt[IssueRs1] != '0) ||
                      (IssueRs2 != REG_ZERO && cnt[IssueRs2] != '0);
  assign waw_full   = IssueWrites && IssueRd != REG_ZERO && full_v[IssueRd];
  assign IssueReady = !raw && !waw_full;
  assign issue_fire = IssueValid && IssueReady;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = issue_fire && IssueWrites && IssueRd == reg_idx_t'(r);
    assign dec = WbValid && WbRd == reg_idx_t'(r);
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk             (clk),
      .reset           (reset),
      .inc             (inc),
      .dec             (dec),
      .clr             (Flush),
      .count           (cnt[r]),
      .nonzero         (nonzero_v[r]),
      .full            (full_v[r]),
      .underflow_pulse (uf_v[r])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (IssueValid && !IssueReady && stall_count_q != '1)
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    underflow_d = underflow_q | (|uf_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      stall_count_q <= stall_count_d;
      underflow_q   <= underflow_d;
    end
  end

  assign RegWrite      = WbValid && WbRd != REG_ZERO;
  assign WriteRegister = WbRd;
  assign BusyMask      = nonzero_v;
  assign StallCount    = stall_count_q;
  assign Underflow     = underflow_q;
endmodule
